// File: rtl/rvfi_trk_pkg.sv
// Shared types for the RVFI commit tracker.
//   rvfi_pkt_t   : one RVFI channel's worth of retire information
//   trk_entry_t  : per-ROB-tag side-table entry (packet fields + capture flags)
//   rob_idx_width: tag width derived from the ROB depth
package rvfi_trk_pkg;

    function automatic int unsigned rob_idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

    typedef struct packed {
        rvfi_pkt_t pkt;
        logic      disp_done;
        logic      wb_done;
        logic      mem_done;
    } trk_entry_t;

endpackage

// File: rtl/rvfi_trk_table.sv
// ROB-tag-indexed side table holding partially built RVFI records.
//   clk, rst_n        : clock, async active-low reset
//   flush             : clears all capture flags; writes this cycle are dropped
//   disp_* / wb_* / lsu_* : three capture write ports
//   rd_idx            : COMMIT_W read tags (lane 0 in the low bits)
//   rd_entry          : COMMIT_W entries with same-cycle wb/lsu data forwarded
module rvfi_trk_table
    import rvfi_trk_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned COMMIT_W  = 2,
    parameter int unsigned ROB_IDX_W = rob_idx_width(ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          disp_valid,
    input  logic [ROB_IDX_W-1:0]          disp_rob_idx,
    input  logic [31:0]                   disp_pc,
    input  logic [31:0]                   disp_inst,
    input  logic [4:0]                    disp_rs1_addr,
    input  logic [4:0]                    disp_rs2_addr,
    input  logic [4:0]                    disp_rd_addr,
    input  logic                          wb_valid,
    input  logic [ROB_IDX_W-1:0]          wb_rob_idx,
    input  logic [31:0]                   wb_rs1_rdata,
    input  logic [31:0]                   wb_rs2_rdata,
    input  logic [31:0]                   wb_rd_wdata,
    input  logic [31:0]                   wb_pc_wdata,
    input  logic                          lsu_valid,
    input  logic [ROB_IDX_W-1:0]          lsu_rob_idx,
    input  logic [31:0]                   lsu_addr,
    input  logic [3:0]                    lsu_rmask,
    input  logic [3:0]                    lsu_wmask,
    input  logic [31:0]                   lsu_rdata,
    input  logic [31:0]                   lsu_wdata,
    input  logic [COMMIT_W*ROB_IDX_W-1:0] rd_idx,
    output trk_entry_t [COMMIT_W-1:0]     rd_entry
);

    trk_entry_t tbl [ROB_DEPTH];

    // Port order matters when ports hit the same tag: dispatch first so a
    // writeback/LSU capture in the same cycle still marks its data present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                tbl[i].disp_done <= 1'b0;
                tbl[i].wb_done   <= 1'b0;
                tbl[i].mem_done  <= 1'b0;
            end
        end else begin
            if (disp_valid) begin
                tbl[disp_rob_idx].pkt.pc_rdata  <= disp_pc;
                tbl[disp_rob_idx].pkt.inst      <= disp_inst;
                tbl[disp_rob_idx].pkt.rs1_addr  <= disp_rs1_addr;
                tbl[disp_rob_idx].pkt.rs2_addr  <= disp_rs2_addr;
                tbl[disp_rob_idx].pkt.rd_addr   <= disp_rd_addr;
                tbl[disp_rob_idx].pkt.mem_rmask <= '0;
                tbl[disp_rob_idx].pkt.mem_wmask <= '0;
                tbl[disp_rob_idx].disp_done     <= 1'b1;
                tbl[disp_rob_idx].wb_done       <= 1'b0;
                tbl[disp_rob_idx].mem_done      <= 1'b0;
            end
            if (wb_valid) begin
                tbl[wb_rob_idx].pkt.rs1_rdata <= wb_rs1_rdata;
                tbl[wb_rob_idx].pkt.rs2_rdata <= wb_rs2_rdata;
                tbl[wb_rob_idx].pkt.rd_wdata  <= wb_rd_wdata;
                tbl[wb_rob_idx].pkt.pc_wdata  <= wb_pc_wdata;
                tbl[wb_rob_idx].wb_done       <= 1'b1;
            end
            if (lsu_valid) begin
                tbl[lsu_rob_idx].pkt.mem_addr  <= lsu_addr;
                tbl[lsu_rob_idx].pkt.mem_rmask <= lsu_rmask;
                tbl[lsu_rob_idx].pkt.mem_wmask <= lsu_wmask;
                tbl[lsu_rob_idx].pkt.mem_rdata <= lsu_rdata;
                tbl[lsu_rob_idx].pkt.mem_wdata <= lsu_wdata;
                tbl[lsu_rob_idx].mem_done      <= 1'b1;
            end
        end
    end

    // Read ports forward a writeback/LSU capture aimed at the tag being read,
    // so an instruction finishing and committing in one cycle is complete.
    always_comb begin
        trk_entry_t           e;
        logic [ROB_IDX_W-1:0] idx;
        rd_entry = '0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            idx = rd_idx[k*ROB_IDX_W +: ROB_IDX_W];
            e   = tbl[idx];
            if (!flush && wb_valid && (wb_rob_idx == idx)) begin
                e.pkt.rs1_rdata = wb_rs1_rdata;
                e.pkt.rs2_rdata = wb_rs2_rdata;
                e.pkt.rd_wdata  = wb_rd_wdata;
                e.pkt.pc_wdata  = wb_pc_wdata;
                e.wb_done       = 1'b1;
            end
            if (!flush && lsu_valid && (lsu_rob_idx == idx)) begin
                e.pkt.mem_addr  = lsu_addr;
                e.pkt.mem_rmask = lsu_rmask;
                e.pkt.mem_wmask = lsu_wmask;
                e.pkt.mem_rdata = lsu_rdata;
                e.pkt.mem_wdata = lsu_wdata;
                e.mem_done      = 1'b1;
            end
            rd_entry[k] = e;
        end
    end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Collects per-instruction RVFI records in an out-of-order core and emits
// them, program-ordered, on COMMIT_W RVFI channels one cycle after commit.
//   clk, rst_n        : clock, async active-low reset
//   flush             : invalidate all tracked entries
//   disp_*            : static fields captured at dispatch
//   wb_*              : operands, result and next PC captured at writeback
//   lsu_*             : memory access captured from the LSU
//   commit_valid/_rob_idx : per-lane commit, lane 0 oldest, prefix-contiguous
//   rvfi_*            : registered RVFI channels (channel k in slice k)
//   commit_err        : sticky protocol error
module rvfi_commit_tracker
    import rvfi_trk_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned COMMIT_W  = 2,
    parameter int unsigned ROB_IDX_W = rob_idx_width(ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          disp_valid,
    input  logic [ROB_IDX_W-1:0]          disp_rob_idx,
    input  logic [31:0]                   disp_pc,
    input  logic [31:0]                   disp_inst,
    input  logic [4:0]                    disp_rs1_addr,
    input  logic [4:0]                    disp_rs2_addr,
    input  logic [4:0]                    disp_rd_addr,
    input  logic                          wb_valid,
    input  logic [ROB_IDX_W-1:0]          wb_rob_idx,
    input  logic [31:0]                   wb_rs1_rdata,
    input  logic [31:0]                   wb_rs2_rdata,
    input  logic [31:0]                   wb_rd_wdata,
    input  logic [31:0]                   wb_pc_wdata,
    input  logic                          lsu_valid,
    input  logic [ROB_IDX_W-1:0]          lsu_rob_idx,
    input  logic [31:0]                   lsu_addr,
    input  logic [3:0]                    lsu_rmask,
    input  logic [3:0]                    lsu_wmask,
    input  logic [31:0]                   lsu_rdata,
    input  logic [31:0]                   lsu_wdata,
    input  logic [COMMIT_W-1:0]           commit_valid,
    input  logic [COMMIT_W*ROB_IDX_W-1:0] commit_rob_idx,
    output logic [COMMIT_W-1:0]           rvfi_valid,
    output logic [COMMIT_W*64-1:0]        rvfi_order,
    output logic [COMMIT_W*32-1:0]        rvfi_inst,
    output logic [COMMIT_W*32-1:0]        rvfi_pc_rdata,
    output logic [COMMIT_W*32-1:0]        rvfi_pc_wdata,
    output logic [COMMIT_W*32-1:0]        rvfi_rs1_rdata,
    output logic [COMMIT_W*32-1:0]        rvfi_rs2_rdata,
    output logic [COMMIT_W*32-1:0]        rvfi_rd_wdata,
    output logic [COMMIT_W*32-1:0]        rvfi_mem_addr,
    output logic [COMMIT_W*32-1:0]        rvfi_mem_rdata,
    output logic [COMMIT_W*32-1:0]        rvfi_mem_wdata,
    output logic [COMMIT_W*5-1:0]         rvfi_rs1_addr,
    output logic [COMMIT_W*5-1:0]         rvfi_rs2_addr,
    output logic [COMMIT_W*5-1:0]         rvfi_rd_addr,
    output logic [COMMIT_W*4-1:0]         rvfi_mem_rmask,
    output logic [COMMIT_W*4-1:0]         rvfi_mem_wmask,
    output logic                          commit_err
);

    trk_entry_t [COMMIT_W-1:0] rd_entry;
    rvfi_pkt_t                 nxt_pkt [COMMIT_W];
    rvfi_pkt_t                 out_pkt [COMMIT_W];
    logic [COMMIT_W-1:0]       out_valid;
    logic [63:0]               order_cnt;
    logic [63:0]               commit_cnt;
    logic [COMMIT_W-1:0]       cv_inc;
    logic                      prefix_ok;
    logic                      lane_err;
    logic                      disp_hit;

    rvfi_trk_table #(
        .ROB_DEPTH (ROB_DEPTH),
        .COMMIT_W  (COMMIT_W),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_table (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_rob_idx  (disp_rob_idx),
        .disp_pc       (disp_pc),
        .disp_inst     (disp_inst),
        .disp_rs1_addr (disp_rs1_addr),
        .disp_rs2_addr (disp_rs2_addr),
        .disp_rd_addr  (disp_rd_addr),
        .wb_valid      (wb_valid),
        .wb_rob_idx    (wb_rob_idx),
        .wb_rs1_rdata  (wb_rs1_rdata),
        .wb_rs2_rdata  (wb_rs2_rdata),
        .wb_rd_wdata   (wb_rd_wdata),
        .wb_pc_wdata   (wb_pc_wdata),
        .lsu_valid     (lsu_valid),
        .lsu_rob_idx   (lsu_rob_idx),
        .lsu_addr      (lsu_addr),
        .lsu_rmask     (lsu_rmask),
        .lsu_wmask     (lsu_wmask),
        .lsu_rdata     (lsu_rdata),
        .lsu_wdata     (lsu_wdata),
        .rd_idx        (commit_rob_idx),
        .rd_entry      (rd_entry)
    );

    // A legal pattern is 0..01..1; adding one then clears every set bit.
    assign cv_inc    = commit_valid + COMMIT_W'(1);
    assign prefix_ok = ((commit_valid & cv_inc) == '0);

    always_comb begin
        commit_cnt = '0;
        lane_err   = 1'b0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            nxt_pkt[k] = '0;
            if (commit_valid[k]) begin
                commit_cnt = commit_cnt + 64'd1;
                nxt_pkt[k] = rd_entry[k].pkt;
                nxt_pkt[k].order = order_cnt + 64'(k);
                if (rd_entry[k].pkt.rd_addr == '0) begin
                    nxt_pkt[k].rd_wdata = '0;
                end
                if (rd_entry[k].pkt.rs1_addr == '0) begin
                    nxt_pkt[k].rs1_rdata = '0;
                end
                if (rd_entry[k].pkt.rs2_addr == '0) begin
                    nxt_pkt[k].rs2_rdata = '0;
                end
                if (!rd_entry[k].disp_done || !rd_entry[k].wb_done ||
                    (((rd_entry[k].pkt.mem_rmask | rd_entry[k].pkt.mem_wmask) != '0) &&
                     !rd_entry[k].mem_done)) begin
                    lane_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            order_cnt  <= '0;
            commit_err <= 1'b0;
            for (int unsigned k = 0; k < COMMIT_W; k++) begin
                out_pkt[k] <= '0;
            end
        end else begin
            out_valid <= commit_valid;
            order_cnt <= order_cnt + commit_cnt;
            for (int unsigned k = 0; k < COMMIT_W; k++) begin
                out_pkt[k] <= nxt_pkt[k];
            end
            if (lane_err || ((commit_valid != '0) && !prefix_ok)) begin
                commit_err <= 1'b1;
            end
        end
    end

    assign rvfi_valid = out_valid;

    for (genvar g = 0; g < COMMIT_W; g++) begin : g_chan
        assign rvfi_order    [g*64 +: 64] = out_pkt[g].order;
        assign rvfi_inst     [g*32 +: 32] = out_pkt[g].inst;
        assign rvfi_pc_rdata [g*32 +: 32] = out_pkt[g].pc_rdata;
        assign rvfi_pc_wdata [g*32 +: 32] = out_pkt[g].pc_wdata;
        assign rvfi_rs1_rdata[g*32 +: 32] = out_pkt[g].rs1_rdata;
        assign rvfi_rs2_rdata[g*32 +: 32] = out_pkt[g].rs2_rdata;
        assign rvfi_rd_wdata [g*32 +: 32] = out_pkt[g].rd_wdata;
        assign rvfi_mem_addr [g*32 +: 32] = out_pkt[g].mem_addr;
        assign rvfi_mem_rdata[g*32 +: 32] = out_pkt[g].mem_rdata;
        assign rvfi_mem_wdata[g*32 +: 32] = out_pkt[g].mem_wdata;
        assign rvfi_rs1_addr [g*5 +: 5]   = out_pkt[g].rs1_addr;
        assign rvfi_rs2_addr [g*5 +: 5]   = out_pkt[g].rs2_addr;
        assign rvfi_rd_addr  [g*5 +: 5]   = out_pkt[g].rd_addr;
        assign rvfi_mem_rmask[g*4 +: 4]   = out_pkt[g].mem_rmask;
        assign rvfi_mem_wmask[g*4 +: 4]   = out_pkt[g].mem_wmask;
    end

    // Dispatching into a tag that is retiring in the same cycle is a core bug.
    always_comb begin
        disp_hit = 1'b0;
        for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (disp_valid && commit_valid[k] &&
                (commit_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] == disp_rob_idx)) begin
                disp_hit = 1'b1;
            end
        end
    end

    a_no_disp_on_commit: assert property (@(posedge clk) disable iff (!rst_n) !disp_hit);

endmodule
